// File: rtl/uart_rx_ctrl_if.sv
// Bus-side and receiver-side signals of the UART receive controller.
// The controller connects through the slave modport, and the bus/receiver side through the master modport.
interface uart_rx_ctrl_if;
    logic [5:0]  uart_cr_i;
    logic [15:0] uart_brr_i;
    logic        rx_rc_i;
    logic        rx_pe_i;
    logic [7:0]  rx_data_i;
    logic        rd_en_i;
    logic [2:0]  clr_i;
    logic [2:0]  ie_i;
    logic [7:0]  rd_data_o;
    logic [15:0] status_o;
    logic        irq_o;

    modport master (
        output uart_cr_i, uart_brr_i, rx_rc_i, rx_pe_i, rx_data_i, rd_en_i, clr_i, ie_i,
        input  rd_data_o, status_o, irq_o
    );

    modport slave (
        input  uart_cr_i, uart_brr_i, rx_rc_i, rx_pe_i, rx_data_i, rd_en_i, clr_i, ie_i,
        output rd_data_o, status_o, irq_o
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO with parity tags, sticky OVR/PERR/TO flags,
// idle timeout and one registered interrupt.
module uart_rx_ctrl #(
    parameter int DEPTH     = 8,
    parameter int RX_THRESH = 1,
    parameter int TO_BITS   = 40
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    uart_rx_ctrl_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(TO_BITS + 1);
    localparam logic [4:0]    DEPTH_C   = 5'(DEPTH);
    localparam logic [4:0]    THRESH_C  = 5'(RX_THRESH);
    localparam logic [BW-1:0] TO_BITS_C = BW'(TO_BITS);

    logic [DATA_W:0]   mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [4:0]        count;
    logic              rc_q, ovr, perr, to_flag, irq_q;
    logic [15:0]       presc, presc_d;
    logic [BW-1:0]     bit_cnt, bit_cnt_d;
    logic              ue, push_ev, pop, drop, store, idle_clr;
    logic [DATA_W:0]   head;

    always_comb begin
        ue       = bus.uart_cr_i[0];
        push_ev  = bus.rx_rc_i & ~rc_q & ue;
        pop      = bus.rd_en_i & (count != 5'd0);
        // A pop in the same cycle frees the slot, so a push at full is still stored.
        drop     = push_ev & (count == DEPTH_C) & ~pop;
        store    = push_ev & ~drop;
        idle_clr = push_ev | pop | (count == 5'd0);
    end

    // Bit-time prescaler and idle bit counter; the counter parks at TO_BITS.
    always_comb begin
        presc_d   = presc;
        bit_cnt_d = bit_cnt;
        if (idle_clr) begin
            presc_d   = '0;
            bit_cnt_d = '0;
        end else if (bus.uart_brr_i != 16'd0 && bit_cnt != TO_BITS_C) begin
            if (presc >= bus.uart_brr_i - 16'd1) begin
                presc_d   = '0;
                bit_cnt_d = bit_cnt + BW'(1);
            end else begin
                presc_d = presc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rc_q    <= 1'b0;
            irq_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovr     <= 1'b0;
            perr    <= 1'b0;
            to_flag <= 1'b0;
            presc   <= '0;
            bit_cnt <= '0;
        end else begin
            rc_q  <= bus.rx_rc_i;
            irq_q <= (bus.ie_i[0] & (count >= THRESH_C)) |
                     (bus.ie_i[1] & (ovr | perr)) |
                     (bus.ie_i[2] & to_flag);
            if (!ue) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                ovr     <= 1'b0;
                perr    <= 1'b0;
                to_flag <= 1'b0;
                presc   <= '0;
                bit_cnt <= '0;
            end else begin
                if (store) wr_ptr <= wr_ptr + PW'(1);
                if (pop)   rd_ptr <= rd_ptr + PW'(1);
                count   <= count + {4'd0, store} - {4'd0, pop};
                ovr     <= drop | (ovr & ~bus.clr_i[0]);
                perr    <= (store & bus.rx_pe_i) | (perr & ~bus.clr_i[1]);
                to_flag <= (bit_cnt_d == TO_BITS_C) | (to_flag & ~bus.clr_i[2]);
                presc   <= presc_d;
                bit_cnt <= bit_cnt_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem[wr_ptr] <= {bus.rx_pe_i, bus.rx_data_i};
    end

    assign head          = mem[rd_ptr];
    assign bus.rd_data_o = (count != 5'd0) ? head[DATA_W-1:0] : '0;
    assign bus.status_o  = {3'd0, count, 2'd0, (count != 5'd0) & head[DATA_W],
                            to_flag, perr, ovr, count == DEPTH_C, count != 5'd0};
    assign bus.irq_o     = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized and directed bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;
    localparam int DEPTH     = 8;
    localparam int RX_THRESH = 1;
    localparam int TO_BITS   = 40;

    logic clk;
    logic rst_n;
    uart_rx_ctrl_if ifc ();

    uart_rx_ctrl #(.DEPTH(DEPTH), .RX_THRESH(RX_THRESH), .TO_BITS(TO_BITS)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0]  cur_cr  = 6'd0;
    logic [15:0] cur_brr = 16'd0;
    logic [2:0]  cur_ie  = 3'd0;

    // Reference model: FIFO as a queue, idle time as a plain cycle count.
    logic [8:0] mq[$];
    logic m_ovr, m_perr, m_to, m_irq, m_rc_prev;
    int   m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr = 0; m_perr = 0; m_to = 0; m_irq = 0; m_rc_prev = 0; m_idle = 0;
    endtask

    function automatic logic [7:0] exp_rd();
        return (mq.size() > 0) ? mq[0][7:0] : 8'd0;
    endfunction

    function automatic logic [15:0] exp_st();
        logic [15:0] s;
        int sz;
        sz = mq.size();
        s = '0;
        s[0] = sz > 0;
        s[1] = sz == DEPTH;
        s[2] = m_ovr;
        s[3] = m_perr;
        s[4] = m_to;
        s[5] = (sz > 0) ? mq[0][8] : 1'b0;
        s[12:8] = 5'(sz);
        return s;
    endfunction

    task automatic model_step();
        logic ue, pev, pop, drop, store, clrc, irqn;
        int sz, thr, idle_n;
        sz   = mq.size();
        ue   = ifc.uart_cr_i[0];
        pev  = ifc.rx_rc_i && !m_rc_prev && ue;
        pop  = ifc.rd_en_i && sz > 0;
        irqn = (ifc.ie_i[0] && sz >= RX_THRESH) || (ifc.ie_i[1] && (m_ovr || m_perr)) ||
               (ifc.ie_i[2] && m_to);
        if (!ue) begin
            mq.delete();
            m_ovr = 0; m_perr = 0; m_to = 0; m_idle = 0;
        end else begin
            drop  = pev && sz == DEPTH && !pop;
            store = pev && !drop;
            clrc  = pev || pop || sz == 0;
            thr   = TO_BITS * int'(ifc.uart_brr_i);
            if (clrc) idle_n = 0;
            else if (thr != 0) idle_n = (m_idle + 1 > thr) ? thr : m_idle + 1;
            else idle_n = m_idle;
            if (pop) void'(mq.pop_front());
            if (store) mq.push_back({ifc.rx_pe_i, ifc.rx_data_i});
            m_ovr  = drop || (m_ovr && !ifc.clr_i[0]);
            m_perr = (store && ifc.rx_pe_i) || (m_perr && !ifc.clr_i[1]);
            m_to   = (thr != 0 && idle_n == thr) || (m_to && !ifc.clr_i[2]);
            m_idle = idle_n;
        end
        m_rc_prev = ifc.rx_rc_i;
        m_irq = irqn;
    endtask

    task automatic cyc(input logic rc, input logic pe, input logic [7:0] d,
                       input logic rd, input logic [2:0] clr);
        ifc.uart_cr_i  = cur_cr;
        ifc.uart_brr_i = cur_brr;
        ifc.ie_i       = cur_ie;
        ifc.rx_rc_i    = rc;
        ifc.rx_pe_i    = pe;
        ifc.rx_data_i  = d;
        ifc.rd_en_i    = rd;
        ifc.clr_i      = clr;
        model_step();
        @(posedge clk);
        #1;
        chk("rd_data", 32'(ifc.rd_data_o), 32'(exp_rd()));
        chk("status", 32'(ifc.status_o), 32'(exp_st()));
        chk("irq", 32'(ifc.irq_o), 32'(m_irq));
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        cyc(1'b1, pe, d, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
    endtask

    task automatic pop1();
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 3'd0);
    endtask

    task automatic flush();
        cur_cr = 6'd0;
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
        cur_cr = 6'd1;
    endtask

    task automatic measure_to(input string tag);
        int k;
        k = 0;
        while (ifc.status_o[4] !== 1'b1 && k < 400) begin
            cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
            k++;
        end
        chk(tag, 32'(k), 32'd160);
    endtask

    initial begin
        int rcp, rdp;
        rst_n = 1'b1;
        ifc.uart_cr_i = '0; ifc.uart_brr_i = '0; ifc.ie_i = '0; ifc.rx_rc_i = 1'b0;
        ifc.rx_pe_i = 1'b0; ifc.rx_data_i = '0; ifc.rd_en_i = 1'b0; ifc.clr_i = '0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd", 32'(ifc.rd_data_o), 32'd0);
        chk("reset_status", 32'(ifc.status_o), 32'd0);
        chk("reset_irq", 32'(ifc.irq_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_cr = 6'd1;

        // Basic push and pop ordering
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        chk("cnt3", 32'(ifc.status_o[12:8]), 32'd3);
        chk("head41", 32'(ifc.rd_data_o), 32'h41);
        pop1(); chk("head42", 32'(ifc.rd_data_o), 32'h42);
        pop1(); chk("head43", 32'(ifc.rd_data_o), 32'h43);
        pop1(); chk("empty_rd", 32'(ifc.rd_data_o), 32'd0);
        chk("empty_rxne", 32'(ifc.status_o[0]), 32'd0);

        // Overrun at full, then push with simultaneous pop at full
        flush();
        for (int i = 0; i < 8; i++) push(8'(i), 1'b0);
        push(8'h08, 1'b0);
        chk("ovr_set", 32'(ifc.status_o[2]), 32'd1);
        chk("full_set", 32'(ifc.status_o[1]), 32'd1);
        chk("ovr_head", 32'(ifc.rd_data_o), 32'h00);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'b001);
        chk("ovr_clr", 32'(ifc.status_o[2]), 32'd0);
        cyc(1'b1, 1'b0, 8'h09, 1'b1, 3'd0);
        chk("full_pp_cnt", 32'(ifc.status_o[12:8]), 32'd8);
        chk("full_pp_ovr", 32'(ifc.status_o[2]), 32'd0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
        repeat (7) pop1();
        chk("last_entry", 32'(ifc.rd_data_o), 32'h09);

        // Parity error flag, head tag and error interrupt
        flush();
        push(8'h55, 1'b1);
        chk("perr_set", 32'(ifc.status_o[3]), 32'd1);
        chk("head_pe", 32'(ifc.status_o[5]), 32'd1);
        cur_ie = 3'b010;
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
        chk("irq_perr", 32'(ifc.irq_o), 32'd1);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'b010);
        chk("perr_clr", 32'(ifc.status_o[3]), 32'd0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
        chk("irq_drop", 32'(ifc.irq_o), 32'd0);
        cur_ie = 3'd0;

        // Idle timeout latency and restart on pop
        cur_brr = 16'd4;
        flush();
        cyc(1'b1, 1'b0, 8'hA0, 1'b0, 3'd0);
        measure_to("to_latency");
        flush();
        push(8'hA1, 1'b0);
        cyc(1'b1, 1'b0, 8'hA2, 1'b0, 3'd0);
        repeat (99) cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
        chk("to_early", 32'(ifc.status_o[4]), 32'd0);
        pop1();
        measure_to("to_restart");

        // Long rx_rc_i level pushes once
        flush();
        repeat (5) cyc(1'b1, 1'b0, 8'h77, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
        chk("level_once", 32'(ifc.status_o[12:8]), 32'd1);

        // Flush with data and OVR pending
        flush();
        for (int i = 0; i < 9; i++) push(8'(8'h10 + i), 1'b0);
        repeat (4) pop1();
        chk("pre_flush_cnt", 32'(ifc.status_o[12:8]), 32'd4);
        chk("pre_flush_ovr", 32'(ifc.status_o[2]), 32'd1);
        flush();
        chk("flush_status", 32'(ifc.status_o), 32'd0);
        chk("flush_rd", 32'(ifc.rd_data_o), 32'd0);

        // Asynchronous reset mid-cycle
        cur_ie = 3'b001;
        push(8'h31, 1'b0); push(8'h32, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rd", 32'(ifc.rd_data_o), 32'd0);
        chk("async_status", 32'(ifc.status_o), 32'd0);
        chk("async_irq", 32'(ifc.irq_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized segments: busy traffic, then a quiet tail so timeouts occur
        for (int seg = 0; seg < 6; seg++) begin
            cur_brr = 16'($urandom_range(0, 3));
            cur_ie  = 3'($urandom);
            flush();
            cur_cr = 6'($urandom) | 6'd1;
            rcp = $urandom_range(1, 5);
            rdp = $urandom_range(0, 5);
            for (int i = 0; i < 500; i++) begin
                if (i == 250) begin
                    rcp = 0;
                    rdp = 0;
                end
                cyc($urandom_range(0, 7) < rcp, 1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(0, 7) < rdp,
                    ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
